// File: rtl/trace_capture.sv
// trace_capture: captures core trace words into a FIFO. When the core traps,
// the FIFO stops taking new words and drains to the consumer. Once it is
// empty, done is raised and held until reset.
//
// Parameters:
//   DEPTH  FIFO depth in 36-bit words (power of two, >= 2)
//   CNT_W  width of the dropped-word counter (saturates at all-ones)
// Ports:
//   clk          single clock, rising edge
//   resetn       synchronous active-low reset
//   trace_valid  trace word present this cycle (ignored after trap)
//   trace_data   36-bit trace word
//   trap         core halted; moves the block from RUN to DRAIN
//   out_valid    head word available (level != 0)
//   out_data     head word, read straight from storage registers
//   out_ready    consumer accepts head word
//   level        number of stored words, 0..DEPTH
//   drop_count   words lost because the FIFO was full
//   done         stream finished and fully drained
module trace_capture #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     trace_valid,
  input  logic [35:0]              trace_data,
  input  logic                     trap,
  output logic                     out_valid,
  output logic [35:0]              out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [35:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     lvl, lvl_nxt;
  logic [CNT_W-1:0] drops;
  logic            push, drop, pop;

  // Fullness is judged on the current level, so a same-cycle pop never
  // makes room for a word arriving at a full FIFO.
  always_comb begin
    push = 1'b0;
    drop = 1'b0;
    if (state == RUN && trace_valid) begin
      if (lvl != FULL) push = 1'b1;
      else             drop = 1'b1;
    end
    pop = (lvl != '0) && out_ready;
  end

  always_comb begin
    lvl_nxt = lvl;
    if (push && !pop)      lvl_nxt = lvl + 1'b1;
    else if (!push && pop) lvl_nxt = lvl - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (trap) state_nxt = DRAIN;
      // Looks at the post-edge level so DRAIN entered empty still leaves on
      // the next edge, and the last pop lands in DONE on the same edge.
      DRAIN:   if (lvl_nxt == '0) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
      drops  <= '0;
    end else begin
      state <= state_nxt;
      lvl   <= lvl_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop && drops != '1) drops <= drops + 1'b1;
    end
  end

  // Storage is not reset; out_data is only meaningful while out_valid=1.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= trace_data;
  end

  assign out_valid  = (lvl != '0);
  assign out_data   = mem[rd_ptr];
  assign level      = lvl;
  assign drop_count = drops;
  assign done       = (state == DONE);

endmodule

// File: tb/tb_trace_capture.sv
module tb_trace_capture;

  logic        clk = 1'b0;
  logic        resetn;
  logic        trace_valid;
  logic [35:0] trace_data;
  logic        trap;
  logic        out_ready;

  logic        out_valid;
  logic [35:0] out_data;
  logic [4:0]  level;
  logic [15:0] drop_count;
  logic        done;

  logic        s_out_valid;
  logic [35:0] s_out_data;
  logic [4:0]  s_level;
  logic [3:0]  s_drop_count;
  logic        s_done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  trace_capture #(.DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .trace_valid(trace_valid),
    .trace_data(trace_data), .trap(trap), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .level(level),
    .drop_count(drop_count), .done(done)
  );

  trace_capture #(.DEPTH(16), .CNT_W(4)) dut_sat (
    .clk(clk), .resetn(resetn), .trace_valid(trace_valid),
    .trace_data(trace_data), .trap(trap), .out_valid(s_out_valid),
    .out_data(s_out_data), .out_ready(out_ready), .level(s_level),
    .drop_count(s_drop_count), .done(s_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every accepted head word must match the oldest expected word.
  always @(negedge clk) begin
    if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got %0h expected none", out_data);
      end else begin
        check("out_data", {28'h0, out_data}, {28'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; trace_valid = 1'b0; trap = 1'b0; out_ready = 1'b0;
    trace_data = '0;
    step();
    resetn = 1'b1;
    exp_q.delete();
  endtask

  task automatic wait_empty(input int max_cyc);
    int c = 0;
    while (exp_q.size() != 0 && c < max_cyc) begin
      step();
      c++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  logic [15:0] lfsr;
  int w, cyc;

  initial begin
    // Reset state
    resetn = 1'b0; trace_valid = 1'b0; trap = 1'b0; out_ready = 1'b0;
    trace_data = '0;
    step(); step();
    check("rst_level", 64'(level), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    resetn = 1'b1;

    // Single word, one-cycle latency
    trace_valid = 1'b1; trace_data = 36'h0_0000_1234; out_ready = 1'b1;
    exp_q.push_back(36'h0_0000_1234);
    step();
    trace_valid = 1'b0;
    check("single_out_valid", 64'(out_valid), 64'd1);
    check("single_level", 64'(level), 64'd1);
    step();
    check("single_level_after", 64'(level), 64'd0);
    check("single_out_valid_after", 64'(out_valid), 64'd0);

    // Overflow: 20 words into 16 slots, then a full-cycle push+pop
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      trace_valid = 1'b1; trace_data = 36'(i);
      if (i < 16) exp_q.push_back(36'(i));
      step();
    end
    trace_valid = 1'b0;
    check("ovf_level", 64'(level), 64'd16);
    check("ovf_drop", 64'(drop_count), 64'd4);
    trace_valid = 1'b1; trace_data = 36'd99; out_ready = 1'b1;
    step();
    trace_valid = 1'b0;
    check("ovf_pop_no_rescue_level", 64'(level), 64'd15);
    check("ovf_pop_no_rescue_drop", 64'(drop_count), 64'd5);
    wait_empty(40);
    check("ovf_level_drained", 64'(level), 64'd0);

    // Streaming with irregular valid/ready
    do_reset();
    lfsr = 16'hACE1; w = 0; cyc = 0;
    while (w < 100 && cyc < 2000) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      out_ready = lfsr[3] | lfsr[5];
      trace_valid = lfsr[0] && (level < 5'd16);
      if (trace_valid) begin
        trace_data = 36'h5_0000_0000 + 36'(w);
        exp_q.push_back(trace_data);
        w++;
      end
      step();
      cyc++;
    end
    trace_valid = 1'b0; out_ready = 1'b1;
    check("stream_words_sent", 64'(w), 64'd100);
    wait_empty(40);
    check("stream_drop", 64'(drop_count), 64'd0);
    check("stream_level", 64'(level), 64'd0);

    // Trap drain
    do_reset();
    for (int i = 0; i < 5; i++) begin
      trace_valid = 1'b1; trace_data = 36'hA_0000_0000 + 36'(i);
      exp_q.push_back(trace_data);
      step();
    end
    trace_valid = 1'b1; trap = 1'b1; trace_data = 36'hA_0000_0005;
    exp_q.push_back(trace_data);
    step();
    check("trap_level", 64'(level), 64'd6);
    check("trap_done_early", 64'(done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      trace_valid = 1'b1; trap = i[0]; trace_data = 36'hB_0000_0000 + 36'(i);
      step();
    end
    trace_valid = 1'b0; trap = 1'b0;
    check("drain_ignore_level", 64'(level), 64'd6);
    check("drain_ignore_drop", 64'(drop_count), 64'd0);
    out_ready = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 30) begin
      step();
      cyc++;
    end
    check("drain_done", 64'(done), 64'd1);
    check("drain_all_out", 64'(exp_q.size()), 64'd0);
    check("drain_level", 64'(level), 64'd0);
    trace_valid = 1'b1; trace_data = 36'hC_0000_0000;
    step(); step();
    trace_valid = 1'b0;
    check("done_hold", 64'(done), 64'd1);
    check("done_ignore_level", 64'(level), 64'd0);

    // Trap with empty FIFO: DRAIN then DONE on the next edge
    do_reset();
    trap = 1'b1;
    step();
    trap = 1'b0;
    check("empty_trap_not_done", 64'(done), 64'd0);
    step();
    check("empty_trap_done", 64'(done), 64'd1);

    // Reset mid-drain discards stored words
    do_reset();
    for (int i = 0; i < 3; i++) begin
      trace_valid = 1'b1; trace_data = 36'hD_0000_0000 + 36'(i);
      step();
    end
    trace_valid = 1'b0; trap = 1'b1;
    step();
    trap = 1'b0; trace_valid = 1'b1; trace_data = 36'hD_FFFF_FFFF;
    step();
    trace_valid = 1'b0;
    check("middrain_level", 64'(level), 64'd3);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("middrain_rst_level", 64'(level), 64'd0);
    check("middrain_rst_valid", 64'(out_valid), 64'd0);
    check("middrain_rst_done", 64'(done), 64'd0);
    check("middrain_rst_drop", 64'(drop_count), 64'd0);
    out_ready = 1'b1;
    step(); step();
    check("middrain_no_stale", 64'(out_valid), 64'd0);
    trace_valid = 1'b1; trace_data = 36'hE_0000_0042;
    exp_q.push_back(trace_data);
    step();
    trace_valid = 1'b0;
    check("middrain_run_push", 64'(out_valid), 64'd1);
    wait_empty(5);

    // Drop counter saturation (CNT_W=4 instance)
    do_reset();
    for (int i = 0; i < 36; i++) begin
      trace_valid = 1'b1; trace_data = 36'hF_0000_0000 + 36'(i);
      step();
    end
    check("sat_level", 64'(s_level), 64'd16);
    check("sat_drop", 64'(s_drop_count), 64'd15);
    check("wide_drop", 64'(drop_count), 64'd20);
    for (int i = 0; i < 5; i++) step();
    trace_valid = 1'b0;
    check("sat_drop_hold", 64'(s_drop_count), 64'd15);
    do_reset();
    check("sat_rst_drop", 64'(s_drop_count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in 36-bit words; power of two, >= 2.
REQ-002 SHALL have parameter CNT_W, default 16, width of the dropped-word counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port resetn  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 SHALL have port trace_valid  input  1  core trace word present this cycle.
REQ-006 SHALL have port trace_data  input  36  core trace word.
REQ-007 SHALL have port trap  input  1  core halted; starts end-of-run drain.
REQ-008 SHALL have port out_valid  output  1  head word available to consumer.
REQ-009 SHALL have port out_data  output  36  head word; meaningful only while out_valid=1.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head word.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
REQ-012 SHALL have port drop_count  output  CNT_W  trace words lost to overflow.
REQ-013 SHALL have port done  output  1  trace stream finished and fully drained.

Function
REQ-014 SHALL implement states RUN, DRAIN, DONE; RUN after reset.
REQ-015 Push: in RUN, trace_valid=1 and level<DEPTH -> word written at tail at that edge; level<DEPTH evaluated before any same-cycle pop.
REQ-016 Overflow: in RUN, trace_valid=1 and level==DEPTH -> word discarded, drop_count+1, saturating at all-ones; simultaneous pop does not rescue the word.
REQ-017 Pop: out_valid=1 and out_ready=1 -> head word removed at that edge.
REQ-018 out_valid SHALL equal (level!=0); out_data SHALL be the oldest stored word, from registers only.
REQ-019 Latency: word pushed at edge N SHALL appear on out_data with out_valid=1 in the cycle after edge N when the FIFO was empty.
REQ-020 Simultaneous push and pop with 0<level<DEPTH: both occur, level unchanged, ordering preserved.
REQ-021 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH nor underflow below 0.
REQ-022 out_valid SHALL not depend combinationally on out_ready.
REQ-023 RUN -> DRAIN on any edge where trap=1; a trace_valid word in that same cycle SHALL still be pushed (or dropped) per REQ-015/016.
REQ-024 In DRAIN and DONE, trace_valid and trap SHALL be ignored; no push, no drop count.
REQ-025 DRAIN -> DONE on the edge where level becomes 0 (including DRAIN entered with level already 0: transition on next edge).
REQ-026 done SHALL be 1 exactly in DONE; DONE held until reset.

Reset
REQ-027 resetn=0 at an edge SHALL set state RUN, pointers 0, level 0, drop_count 0, done 0, out_valid 0, regardless of state or pending traffic.
REQ-028 Storage contents need not be reset; out_data is don't-care while out_valid=0.
REQ-029 Reset mid-drain SHALL discard all stored words; none appear on out_* afterward.

Verification
REQ-030 Single word: after reset, trace_valid=1 data 36'h0_0000_1234 one cycle, out_ready=1 -> next cycle out_valid=1 out_data=36'h000001234, then level 0.
REQ-031 Overflow: out_ready=0, 20 consecutive words 0..19 (DEPTH=16) -> level=16, drop_count=4; then out_ready=1 -> words 0..15 in order, no 16..19.
REQ-032 Streaming: 100 words with trace_valid and out_ready both toggled pseudo-randomly, level<DEPTH kept -> all 100 delivered in order, drop_count=0, pointers wrap several times.
REQ-033 Trap drain: 5 words stored, out_ready=0, trap=1 with trace_valid=1 same cycle (word 5) -> level=6, DRAIN; further trace_valid ignored; out_ready=1 -> 6 words out, then done=1.
REQ-034 Reset mid-drain: in DRAIN with level=3, resetn=0 one edge -> level 0, out_valid 0, done 0, state RUN, drop_count 0.
REQ-035 Saturation: CNT_W=4, FIFO full, 20 more trace words -> drop_count=15 and stays 15.
